vga_timing: RTL and testbench

VGA 640x480@60 timing generator: the scan source for the pixel renderer. Produces the current pixel coordinate (x, y) that drives the object renderer, takes back the combinational colour for that pixel, and emits registered, blank-gated RGB with hsync/vsync to the DAC pins. Also emits a once-per-frame tick so game logic can update ball and paddle positions during vertical blanking.

---
 rtl/vga_timing.sv | 143 ++++++++++++++
 tb/tb_vga_timing.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/vga_timing.sv
// VGA 640x480@60 scan generator: pixel counters, blank-gated registered RGB and sync, frame tick.
// Optional macro PIXEL_DIV2_EN: 50 MHz clk with an internal divide-by-two pixel enable.
module vga_timing #(
    parameter int ACTIVE_WIDTH  = 640,
    parameter int H_FRONT       = 16,
    parameter int H_SYNC        = 96,
    parameter int H_BACK        = 48,
    parameter int ACTIVE_HEIGHT = 480,
    parameter int V_FRONT       = 10,
    parameter int V_SYNC        = 2,
    parameter int V_BACK        = 33
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] r_in,
    input  logic [3:0] g_in,
    input  logic [3:0] b_in,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       hsync,
    output logic       vsync,
    output logic [3:0] vga_r,
    output logic [3:0] vga_g,
    output logic [3:0] vga_b,
    output logic       active,
    output logic       frame_tick
);

    localparam int H_TOTAL = ACTIVE_WIDTH + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = ACTIVE_HEIGHT + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT  = 10'(ACTIVE_WIDTH);
    localparam logic [9:0] V_ACT  = 10'(ACTIVE_HEIGHT);
    localparam logic [9:0] HS_BEG = 10'(ACTIVE_WIDTH + H_FRONT);
    localparam logic [9:0] HS_END = 10'(ACTIVE_WIDTH + H_FRONT + H_SYNC);
    localparam logic [9:0] VS_BEG = 10'(ACTIVE_HEIGHT + V_FRONT);
    localparam logic [9:0] VS_END = 10'(ACTIVE_HEIGHT + V_FRONT + V_SYNC);

    logic [9:0] r_x;
    logic [9:0] r_y;
    logic [9:0] w_x_nxt;
    logic [9:0] w_y_nxt;
    logic       w_step;
    logic       w_vis;
    logic       w_hs_n;
    logic       w_vs_n;
    logic       w_tick;
    logic       r_hsync;
    logic       r_vsync;
    logic       r_active;
    logic       r_tick;
    logic [3:0] r_r;
    logic [3:0] r_g;
    logic [3:0] r_b;

`ifdef PIXEL_DIV2_EN
    logic r_pix_en;

    // Pixel enable: high on every other clk, first step on the 2nd clk after reset
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pix_en <= 1'b0;
        end else begin
            r_pix_en <= ~r_pix_en;
        end
    end

    assign w_step = r_pix_en;
`else
    assign w_step = 1'b1;
`endif

    // Next counter values and decode of the current scan position
    always_comb begin
        w_x_nxt = r_x + 10'd1;
        w_y_nxt = r_y;
        if (r_x == H_LAST) begin
            w_x_nxt = 10'd0;
            if (r_y == V_LAST) begin
                w_y_nxt = 10'd0;
            end else begin
                w_y_nxt = r_y + 10'd1;
            end
        end else begin
            w_y_nxt = r_y;
        end
        w_vis  = (r_x < H_ACT) && (r_y < V_ACT);
        w_hs_n = !((r_x >= HS_BEG) && (r_x < HS_END));
        w_vs_n = !((r_y >= VS_BEG) && (r_y < VS_END));
        w_tick = (r_x == 10'd0) && (r_y == V_ACT);
    end

    // Scan position counters
    always_ff @(posedge clk) begin
        if (reset) begin
            r_x <= 10'd0;
            r_y <= 10'd0;
        end else if (w_step) begin
            r_x <= w_x_nxt;
            r_y <= w_y_nxt;
        end else begin
            r_x <= r_x;
            r_y <= r_y;
        end
    end

    // Output stage: everything registered from the same position so no skew between pins
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hsync  <= 1'b1;
            r_vsync  <= 1'b1;
            r_active <= 1'b0;
            r_tick   <= 1'b0;
            r_r      <= 4'd0;
            r_g      <= 4'd0;
            r_b      <= 4'd0;
        end else if (w_step) begin
            r_hsync  <= w_hs_n;
            r_vsync  <= w_vs_n;
            r_active <= w_vis;
            r_tick   <= w_tick;
            r_r      <= w_vis ? r_in : 4'd0;
            r_g      <= w_vis ? g_in : 4'd0;
            r_b      <= w_vis ? b_in : 4'd0;
        end else begin
            // tick drops on the idle clk so it stays one clk wide
            r_tick   <= 1'b0;
        end
    end

    assign x          = r_x;
    assign y          = r_y;
    assign hsync      = r_hsync;
    assign vsync      = r_vsync;
    assign active     = r_active;
    assign frame_tick = r_tick;
    assign vga_r      = r_r;
    assign vga_g      = r_g;
    assign vga_b      = r_b;

endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing: a shrunken-timing instance against a table and an arithmetic scan
// model, plus a full 640x480 instance for the one-line hsync/wrap checks.
module tb_vga_timing;

`ifdef PIXEL_DIV2_EN
    localparam int DIV = 2;
`else
    localparam int DIV = 1;
`endif

    // shrunken timing for the small instance
    localparam int AW = 16, HF = 2, HS = 4, HB = 3;
    localparam int AH = 12, VF = 2, VS = 2, VB = 3;
    localparam int HT = AW + HF + HS + HB;
    localparam int VT = AH + VF + VS + VB;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] r_in = 4'd0, g_in = 4'd0, b_in = 4'd0;

    logic [9:0] x, y, f_x, f_y;
    logic       hsync, vsync, active, frame_tick;
    logic       f_hsync, f_vsync, f_active, f_frame_tick;
    logic [3:0] vga_r, vga_g, vga_b, f_vga_r, f_vga_g, f_vga_b;

    int tests = 0;
    int fails = 0;

    // model state: clk edges since the last reset edge, colour captured on the last step edge
    int          c = 0;
    logic [11:0] step_rgb = 12'd0;

    always #5 clk = ~clk;

    vga_timing #(
        .ACTIVE_WIDTH(AW), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .ACTIVE_HEIGHT(AH), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
    ) u_small (
        .clk(clk), .reset(reset), .r_in(r_in), .g_in(g_in), .b_in(b_in),
        .x(x), .y(y), .hsync(hsync), .vsync(vsync),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .active(active), .frame_tick(frame_tick)
    );

    vga_timing u_full (
        .clk(clk), .reset(reset), .r_in(r_in), .g_in(g_in), .b_in(b_in),
        .x(f_x), .y(f_y), .hsync(f_hsync), .vsync(f_vsync),
        .vga_r(f_vga_r), .vga_g(f_vga_g), .vga_b(f_vga_b),
        .active(f_active), .frame_tick(f_frame_tick)
    );

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // one clk edge with model bookkeeping, then sample 1 time unit later
    task automatic tick();
        @(posedge clk);
        if (reset) begin
            c = 0;
        end else begin
            c++;
            if (c % DIV == 0) step_rgb = {r_in, g_in, b_in};
        end
        #1;
    endtask

    // expected {x,y,hsync,vsync,active,rgb,frame_tick} of the small instance
    function automatic logic [34:0] model_exp();
        int s, p, px, py;
        logic vis, stepedge;
        s = c / DIV;
        stepedge = (c > 0) && (c % DIV == 0);
        if (s == 0) return {10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 12'd0, 1'b0};
        p   = s - 1;
        px  = p % HT;
        py  = (p / HT) % VT;
        vis = (px < AW) && (py < AH);
        return {10'(s % HT), 10'((s / HT) % VT),
                1'(!(px >= AW + HF && px < AW + HF + HS)),
                1'(!(py >= AH + VF && py < AH + VF + VS)),
                vis, (vis ? step_rgb : 12'd0),
                1'(stepedge && px == 0 && py == AH)};
    endfunction

    typedef struct {
        int          adv;
        logic [11:0] rgb;
        logic [9:0]  ex;
        logic [9:0]  ey;
        logic        ea;
        logic        ehs;
        logic        evs;
        logic        etk;
        logic [11:0] eo;
    } vec_t;

    vec_t tbl[14];

    initial begin
        logic [34:0] e;
        int          low;
        logic        prev_hs, wrap_seen;
        logic [9:0]  prev_x, prev_y;

        // steps counted from reset release on the small instance
        tbl[0]  = '{1,   12'hFFF, 10'd1,  10'd0,  1'b1, 1'b1, 1'b1, 1'b0, 12'hFFF};
        tbl[1]  = '{16,  12'hFFF, 10'd17, 10'd0,  1'b0, 1'b1, 1'b1, 1'b0, 12'h000};
        tbl[2]  = '{2,   12'hFFF, 10'd19, 10'd0,  1'b0, 1'b0, 1'b1, 1'b0, 12'h000};
        tbl[3]  = '{3,   12'hFFF, 10'd22, 10'd0,  1'b0, 1'b0, 1'b1, 1'b0, 12'h000};
        tbl[4]  = '{1,   12'hFFF, 10'd23, 10'd0,  1'b0, 1'b1, 1'b1, 1'b0, 12'h000};
        tbl[5]  = '{2,   12'hFFF, 10'd0,  10'd1,  1'b0, 1'b1, 1'b1, 1'b0, 12'h000};
        tbl[6]  = '{1,   12'h739, 10'd1,  10'd1,  1'b1, 1'b1, 1'b1, 1'b0, 12'h739};
        tbl[7]  = '{274, 12'h739, 10'd0,  10'd12, 1'b0, 1'b1, 1'b1, 1'b0, 12'h000};
        tbl[8]  = '{1,   12'h739, 10'd1,  10'd12, 1'b0, 1'b1, 1'b1, 1'b1, 12'h000};
        tbl[9]  = '{1,   12'h739, 10'd2,  10'd12, 1'b0, 1'b1, 1'b1, 1'b0, 12'h000};
        tbl[10] = '{49,  12'h739, 10'd1,  10'd14, 1'b0, 1'b1, 1'b0, 1'b0, 12'h000};
        tbl[11] = '{50,  12'h739, 10'd1,  10'd16, 1'b0, 1'b1, 1'b1, 1'b0, 12'h000};
        tbl[12] = '{74,  12'h739, 10'd0,  10'd0,  1'b0, 1'b1, 1'b1, 1'b0, 12'h000};
        tbl[13] = '{1,   12'h5A5, 10'd1,  10'd0,  1'b1, 1'b1, 1'b1, 1'b0, 12'h5A5};

        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;

        for (int i = 0; i < 14; i++) begin
            {r_in, g_in, b_in} = tbl[i].rgb;
            repeat (tbl[i].adv * DIV) tick();
            chk($sformatf("tbl%0d_x", i),      x,          tbl[i].ex);
            chk($sformatf("tbl%0d_y", i),      y,          tbl[i].ey);
            chk($sformatf("tbl%0d_active", i), active,     tbl[i].ea);
            chk($sformatf("tbl%0d_hsync", i),  hsync,      tbl[i].ehs);
            chk($sformatf("tbl%0d_vsync", i),  vsync,      tbl[i].evs);
            chk($sformatf("tbl%0d_tick", i),   frame_tick, tbl[i].etk);
            chk($sformatf("tbl%0d_rgb", i),    {vga_r, vga_g, vga_b}, tbl[i].eo);
        end

        // random colour and occasional reset pulses against the arithmetic model
        repeat (3000 * DIV) begin
            r_in  = 4'($urandom);
            g_in  = 4'($urandom);
            b_in  = 4'($urandom);
            reset = ($urandom_range(0, 799) == 0);
            tick();
            e = model_exp();
            chk("model", {x, y, hsync, vsync, active, vga_r, vga_g, vga_b, frame_tick}, e);
        end
        reset = 1'b0;

        // reset held 3 clks mid-scan with bright input
        {r_in, g_in, b_in} = 12'hFFF;
        repeat (137 * DIV) tick();
        reset = 1'b1;
        repeat (3) tick();
        chk("rst_small", {x, y, hsync, vsync, active, vga_r, vga_g, vga_b, frame_tick},
            {10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 12'd0, 1'b0});
        chk("rst_full", {f_x, f_y, f_hsync, f_vsync, f_active, f_vga_r, f_vga_g, f_vga_b, f_frame_tick},
            {10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 12'd0, 1'b0});
        reset = 1'b0;

        // one full-size line: hsync width, falling position and x/y wrap
        low = 0;
        prev_hs = 1'b1;
        prev_x = f_x;
        prev_y = f_y;
        wrap_seen = 1'b0;
        repeat (820 * DIV) begin
            tick();
            if (!f_hsync) low++;
            if (prev_hs && !f_hsync) chk("hs_fall_x", f_x, 10'd657);
            if (prev_x == 10'd799 && f_x != 10'd799) begin
                wrap_seen = 1'b1;
                chk("wrap_x", f_x, 10'd0);
                chk("wrap_y", f_y, prev_y + 10'd1);
            end
            prev_hs = f_hsync;
            prev_x = f_x;
            prev_y = f_y;
        end
        chk("hs_low_clks", low, 96 * DIV);
        chk("wrap_seen", wrap_seen, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
